// File: rtl/segment_scan_decoder.sv
// Receive-side monitor for a multiplexed 7-segment scan: rebuilds four BCD digits per frame.
// Optional macro SEGRX_DP_CAPTURE_EN captures the per-digit decimal point onto o_dp.
module segment_scan_decoder #(
  parameter int WEI_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SETTLE_CYCLES  = 4,
  parameter int STALL_CYCLES   = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sm_wei,
  input  logic [7:0]  sm_duan,
  output logic [15:0] o_data_bcd,
  output logic        o_frame_valid,
  output logic [3:0]  o_dp,
  output logic        o_err_multi,
  output logic        o_glyph_err,
  output logic        o_stalled
);

  localparam int STW = $clog2(STALL_CYCLES + 1);
  localparam logic [3:0]     SEL_IDLE_RAW = (WEI_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  localparam logic [7:0]     SEG_BLANK_RAW = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [7:0]     SETTLE_MAX = 8'(SETTLE_CYCLES);
  localparam logic [7:0]     SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [STW-1:0] STALL_MAX = STW'(STALL_CYCLES);
  localparam logic [STW-1:0] STALL_ONE = STW'(1);

  function automatic logic is_onehot(input logic [3:0] v);
    case (v)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: is_onehot = 1'b1;
      default:                            is_onehot = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    case (v)
      4'b0010: onehot_index = 2'd1;
      4'b0100: onehot_index = 2'd2;
      4'b1000: onehot_index = 2'd3;
      default: onehot_index = 2'd0;
    endcase
  endfunction

  // Normalised gfedcba pattern to BCD code; 0xE marks an unrecognised glyph.
  function automatic logic [3:0] glyph_code(input logic [6:0] pat);
    case (pat)
      7'h3F:          glyph_code = 4'h0;
      7'h06:          glyph_code = 4'h1;
      7'h5B:          glyph_code = 4'h2;
      7'h4F:          glyph_code = 4'h3;
      7'h66:          glyph_code = 4'h4;
      7'h6D:          glyph_code = 4'h5;
      7'h7D, 7'h7C:   glyph_code = 4'h6;
      7'h07:          glyph_code = 4'h7;
      7'h7F:          glyph_code = 4'h8;
      7'h6F, 7'h67:   glyph_code = 4'h9;
      7'h40:          glyph_code = 4'hA;
      7'h00:          glyph_code = 4'hF;
      default:        glyph_code = 4'hE;
    endcase
  endfunction

  logic [3:0]     sel_q_r;
  logic [7:0]     seg_q_r;
  logic           sel_new_r;
  logic [7:0]     settle_cnt_r;
  logic [STW-1:0] stall_cnt_r;
  logic [15:0]    slot_r;
  logic [3:0]     dp_work_r;
  logic [3:0]     seen_r;
  logic           frame_pend_r;
  logic [15:0]    data_bcd_r;
  logic [3:0]     dp_r;
  logic           frame_valid_r;
  logic           err_multi_r;
  logic           glyph_err_r;
  logic           stalled_r;

  logic [3:0]     sel_norm_s;
  logic [3:0]     pin_norm_s;
  logic [7:0]     seg_norm_s;
  logic           dp_bit_s;
  logic           dp_unused_s;
  logic           idle_s;
  logic           valid_s;
  logic           multi_s;
  logic           sel_chg_s;
  logic           new_valid_s;
  logic [1:0]     idx_s;
  logic [3:0]     code_s;
  logic           sample_s;
  logic [7:0]     settle_next_s;
  logic [STW-1:0] stall_next_s;
  logic           stalled_next_s;
  logic [15:0]    slot_next_s;
  logic [3:0]     dp_next_s;
  logic [3:0]     seen_hit_s;
  logic [3:0]     seen_next_s;
  logic           complete_s;

  // Polarity normalisation: 1 means active for selects and segments.
  always_comb begin
    sel_norm_s  = sel_q_r;
    pin_norm_s  = sm_wei;
    seg_norm_s  = seg_q_r;
    if (WEI_ACTIVE_LOW != 0) begin
      sel_norm_s = ~sel_q_r;
      pin_norm_s = ~sm_wei;
    end else begin
      sel_norm_s = sel_q_r;
      pin_norm_s = sm_wei;
    end
    if (SEG_ACTIVE_LOW != 0) begin
      seg_norm_s = ~seg_q_r;
    end else begin
      seg_norm_s = seg_q_r;
    end
`ifdef SEGRX_DP_CAPTURE_EN
    dp_bit_s    = seg_norm_s[7];
    dp_unused_s = 1'b0;
`else
    dp_bit_s    = 1'b0;
    dp_unused_s = seg_norm_s[7];
`endif
  end

  // Select classification, dwell counting, slot writes and stall tracking.
  always_comb begin
    idle_s         = (sel_norm_s == 4'b0000);
    valid_s        = is_onehot(sel_norm_s);
    multi_s        = !idle_s && !valid_s;
    sel_chg_s      = (sm_wei != sel_q_r);
    new_valid_s    = sel_chg_s && is_onehot(pin_norm_s);
    idx_s          = onehot_index(sel_norm_s);
    code_s         = glyph_code(seg_norm_s[6:0]);
    sample_s       = valid_s && (settle_cnt_r == SETTLE_LAST);
    settle_next_s  = settle_cnt_r;
    stall_next_s   = stall_cnt_r;
    stalled_next_s = stalled_r;
    slot_next_s    = slot_r;
    dp_next_s      = dp_work_r;
    seen_hit_s     = seen_r;
    seen_next_s    = seen_r;
    complete_s     = 1'b0;

    // The counter is zero during the first cycle of a new sel_q, so the
    // sample edge lands SETTLE_CYCLES edges after sel_q loads.
    if (sel_chg_s) begin
      settle_next_s = 8'd0;
    end else if (valid_s) begin
      if (settle_cnt_r < SETTLE_MAX) begin
        settle_next_s = settle_cnt_r + 8'd1;
      end else begin
        settle_next_s = settle_cnt_r;
      end
    end else begin
      settle_next_s = 8'd0;
    end

    if (sample_s) begin
      slot_next_s[{idx_s, 2'b00} +: 4] = code_s;
      dp_next_s[idx_s]                 = dp_bit_s;
      seen_hit_s                       = seen_r | (4'b0001 << idx_s);
      if (seen_hit_s == 4'b1111) begin
        complete_s  = 1'b1;
        seen_next_s = 4'b0000;
      end else begin
        complete_s  = 1'b0;
        seen_next_s = seen_hit_s;
      end
    end else begin
      seen_hit_s  = seen_r;
      seen_next_s = seen_r;
    end

    if (new_valid_s) begin
      stall_next_s = {STW{1'b0}};
    end else if (stall_cnt_r < STALL_MAX) begin
      stall_next_s = stall_cnt_r + STALL_ONE;
    end else begin
      stall_next_s = stall_cnt_r;
    end
    stalled_next_s = (stall_next_s >= STALL_MAX);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_q_r       <= SEL_IDLE_RAW;
      seg_q_r       <= SEG_BLANK_RAW;
      sel_new_r     <= 1'b0;
      settle_cnt_r  <= 8'd0;
      stall_cnt_r   <= {STW{1'b0}};
      slot_r        <= 16'hFFFF;
      dp_work_r     <= 4'b0000;
      seen_r        <= 4'b0000;
      frame_pend_r  <= 1'b0;
      data_bcd_r    <= 16'hFFFF;
      dp_r          <= 4'b0000;
      frame_valid_r <= 1'b0;
      err_multi_r   <= 1'b0;
      glyph_err_r   <= 1'b0;
      stalled_r     <= 1'b0;
    end else begin
      sel_q_r       <= sm_wei;
      seg_q_r       <= sm_duan;
      sel_new_r     <= sel_chg_s;
      settle_cnt_r  <= settle_next_s;
      stall_cnt_r   <= stall_next_s;
      slot_r        <= slot_next_s;
      dp_work_r     <= dp_next_s;
      seen_r        <= seen_next_s;
      frame_pend_r  <= complete_s;
      frame_valid_r <= frame_pend_r;
      err_multi_r   <= multi_s && sel_new_r;
      glyph_err_r   <= sample_s && (code_s == 4'hE);
      stalled_r     <= stalled_next_s;
      if (frame_pend_r) begin
        data_bcd_r <= slot_r;
        dp_r       <= dp_work_r;
      end else begin
        data_bcd_r <= data_bcd_r;
        dp_r       <= dp_r;
      end
    end
  end

  assign o_data_bcd    = data_bcd_r;
  assign o_frame_valid = frame_valid_r;
  assign o_dp          = dp_r;
  assign o_err_multi   = err_multi_r;
  assign o_glyph_err   = glyph_err_r;
  assign o_stalled     = stalled_r;

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Directed bench for segment_scan_decoder: drives active-low scans and checks frames, errors and stall.
module tb_segment_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sm_wei;
  logic [7:0]  sm_duan;
  logic [15:0] o_data_bcd;
  logic        o_frame_valid;
  logic [3:0]  o_dp;
  logic        o_err_multi;
  logic        o_glyph_err;
  logic        o_stalled;

  int n_cmp = 0;
  int n_fail = 0;
  int frame_cnt = 0;
  int multi_cnt = 0;
  int glyph_cnt = 0;
  logic [15:0] last_data = 16'h0000;
  logic [3:0]  last_dp = 4'h0;
  int f0, f1, g0, m0;

`ifdef SEGRX_DP_CAPTURE_EN
  localparam logic [3:0] EXP_DP = 4'b1000;
`else
  localparam logic [3:0] EXP_DP = 4'b0000;
`endif

  always #5 clk = ~clk;

  segment_scan_decoder #(
    .WEI_ACTIVE_LOW(1),
    .SEG_ACTIVE_LOW(1),
    .SETTLE_CYCLES(4),
    .STALL_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sm_wei(sm_wei),
    .sm_duan(sm_duan),
    .o_data_bcd(o_data_bcd),
    .o_frame_valid(o_frame_valid),
    .o_dp(o_dp),
    .o_err_multi(o_err_multi),
    .o_glyph_err(o_glyph_err),
    .o_stalled(o_stalled)
  );

  // Pulse bookkeeping sampled on the falling edge.
  always @(negedge clk) begin
    if (o_frame_valid === 1'b1) begin
      frame_cnt = frame_cnt + 1;
      last_data = o_data_bcd;
      last_dp   = o_dp;
    end
    if (o_err_multi === 1'b1) multi_cnt = multi_cnt + 1;
    if (o_glyph_err === 1'b1) glyph_cnt = glyph_cnt + 1;
  end

  function automatic logic [6:0] seg7(input logic [3:0] code);
    case (code)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h40;
      default: seg7 = 7'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int idx, input logic [3:0] code, input logic dp);
    logic [3:0] one;
    one = 4'b0001;
    sm_wei  = ~(one << idx);
    sm_duan = ~{dp, seg7(code)};
  endtask

  task automatic dwell(input int idx, input logic [3:0] code, input logic dp, input int cyc);
    drive(idx, code, dp);
    repeat (cyc) @(negedge clk);
  endtask

  task automatic idle(input int cyc);
    sm_wei  = 4'hF;
    sm_duan = 8'hFF;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_data"}, o_data_bcd, 16'hFFFF);
    check({pfx, "_dp"}, o_dp, 4'h0);
    check({pfx, "_valid"}, o_frame_valid, 1'b0);
    check({pfx, "_multi"}, o_err_multi, 1'b0);
    check({pfx, "_glyph"}, o_glyph_err, 1'b0);
    check({pfx, "_stalled"}, o_stalled, 1'b0);
  endtask

  initial begin
    rst     = 1'b0;
    sm_wei  = 4'hF;
    sm_duan = 8'hFF;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b1;
    idle(2);

    // Normal frame 0342; frame pulse 5 cycles after the last select registers.
    f0 = frame_cnt;
    dwell(3, 4'h0, 1'b0, 8);
    dwell(2, 4'h3, 1'b0, 8);
    dwell(1, 4'h4, 1'b0, 8);
    drive(0, 4'h2, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("t1_valid_c%0d", k), o_frame_valid, (k == 6));
    end
    #1;
    check("t1_frames", frame_cnt - f0, 1);
    check("t1_data", last_data, 16'h0342);

    // Short dwell on digit 2 must not be sampled; out-of-order scan of 1234.
    idle(2);
    f0 = frame_cnt; g0 = glyph_cnt; m0 = multi_cnt;
    dwell(2, 4'h9, 1'b0, 3);
    dwell(0, 4'h4, 1'b0, 8);
    dwell(1, 4'h3, 1'b0, 8);
    dwell(3, 4'h1, 1'b0, 8);
    #1;
    check("t2_no_early_frame", frame_cnt - f0, 0);
    dwell(2, 4'h2, 1'b0, 8);
    idle(2);
    #1;
    check("t2_frames", frame_cnt - f0, 1);
    check("t2_data", last_data, 16'h1234);
    check("t2_glyph", glyph_cnt - g0, 0);
    check("t2_multi", multi_cnt - m0, 0);

    // Multiple selects: one error pulse, no slot write or mask bit.
    f0 = frame_cnt; m0 = multi_cnt; g0 = glyph_cnt;
    sm_wei  = 4'b1100;
    sm_duan = ~{1'b0, seg7(4'h8)};
    repeat (10) @(negedge clk);
    #1;
    check("t3_multi_pulse", multi_cnt - m0, 1);
    dwell(1, 4'h2, 1'b0, 8);
    dwell(3, 4'h0, 1'b0, 8);
    dwell(2, 4'h7, 1'b0, 8);
    #1;
    check("t3_no_frame", frame_cnt - f0, 0);
    dwell(0, 4'h5, 1'b0, 8);
    idle(2);
    #1;
    check("t3_frames", frame_cnt - f0, 1);
    check("t3_data", last_data, 16'h0725);
    check("t3_glyph", glyph_cnt - g0, 0);

    // Unrecognised glyph 0x77 on digit 1 still completes the frame.
    f0 = frame_cnt; g0 = glyph_cnt;
    dwell(3, 4'hF, 1'b0, 8);
    dwell(2, 4'hF, 1'b0, 8);
    sm_wei  = 4'b1101;
    sm_duan = ~8'h77;
    repeat (8) @(negedge clk);
    dwell(0, 4'hF, 1'b0, 8);
    idle(2);
    #1;
    check("t4_glyph", glyph_cnt - g0, 1);
    check("t4_frames", frame_cnt - f0, 1);
    check("t4_data", last_data, 16'hFFEF);

    // Stall: hold digit 0, flag rises after 64 cycles, clears on next select.
    idle(2);
    f0 = frame_cnt;
    drive(0, 4'h1, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 64) check("t5_stall_before", o_stalled, 1'b0);
      if (k == 65) check("t5_stall_after", o_stalled, 1'b1);
    end
    drive(3, 4'h4, 1'b0);
    check("t5_stall_held", o_stalled, 1'b1);
    @(negedge clk);
    check("t5_stall_clear", o_stalled, 1'b0);
    repeat (7) @(negedge clk);
    dwell(2, 4'h5, 1'b0, 8);
    dwell(1, 4'h6, 1'b0, 8);
    idle(2);
    #1;
    check("t5_frames", frame_cnt - f0, 1);
    check("t5_data", last_data, 16'h4561);

    // Reset mid-frame, then rebuild 9876 starting from digit 0.
    dwell(3, 4'h9, 1'b0, 8);
    dwell(2, 4'h8, 1'b0, 8);
    dwell(1, 4'h7, 1'b0, 3);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst1");
    rst = 1'b1;
    f1 = frame_cnt;
    dwell(0, 4'h6, 1'b0, 8);
    #1;
    check("t6_no_early_frame", frame_cnt - f1, 0);
    dwell(3, 4'h9, 1'b0, 8);
    dwell(2, 4'h8, 1'b0, 8);
    dwell(1, 4'h7, 1'b0, 8);
    idle(2);
    #1;
    check("t6_frames", frame_cnt - f1, 1);
    check("t6_data", last_data, 16'h9876);

    // Decimal point on digit 3 of 5.000.
    f0 = frame_cnt;
    dwell(3, 4'h5, 1'b1, 8);
    dwell(2, 4'h0, 1'b0, 8);
    dwell(1, 4'h0, 1'b0, 8);
    dwell(0, 4'h0, 1'b0, 8);
    idle(2);
    #1;
    check("t7_frames", frame_cnt - f0, 1);
    check("t7_data", last_data, 16'h5000);
    check("t7_dp", last_dp, EXP_DP);
    check("t7_dp_out", o_dp, EXP_DP);

    check("total_glyph", glyph_cnt, 1);
    check("total_multi", multi_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/segment_scan_decoder.md
# segment_scan_decoder

Receive-side companion to the multiplexed 7-segment driver. Watches the scanned digit-select (`sm_wei`) and segment (`sm_duan`) lines, rebuilds the four displayed digits as packed BCD, and reports each complete scan frame with a one-cycle valid pulse. It serves as on-chip readback of the reaction-time display and as a self-checking monitor; outside the bench it adds no visible behaviour.

## Interface
- `WEI_ACTIVE_LOW`, 1: 1 means a digit is selected when its `sm_wei` bit is 0; 0 means a digit is selected when its bit is 1.
- `SEG_ACTIVE_LOW`, 1: 1 means a segment is lit when its `sm_duan` bit is 0.
- `SETTLE_CYCLES`, 4: number of consecutive cycles a digit select must be stable before its segments are sampled. Legal range is 1..255.
- `STALL_CYCLES`, 65535: number of idle cycles without a new valid select before stall is flagged. Must be at least 2.
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-low reset.
- `sm_wei` input 4: scanned digit select. Bit n maps to digit n, and digit 0 is the least significant.
- `sm_duan` input 8: segments. Bits [6:0] are segments a..g; bit 7 is the decimal point.
- `o_data_bcd` output 16: last complete frame. Digit n occupies bits [4n+3:4n].
- `o_frame_valid` output 1: one-cycle pulse when `o_data_bcd` updates.
- `o_dp` output 4: decimal point per digit, captured with each frame.
- `o_err_multi` output 1: one-cycle pulse when more than one digit is selected.
- `o_glyph_err` output 1: one-cycle pulse when a sampled segment pattern is not recognised.
- `o_stalled` output 1: level; high while the scan has stopped.

## Operation
- **Input register.** Both inputs are registered once (`sel_q`, `seg_q`). Polarity is then normalised so that 1 means active for both selects and segments.
- **Select decode.**
  - Exactly one bit set: select is valid, with index 0..3.
  - All bits clear: idle. Nothing is sampled and the settle counter holds at 0.
  - Two or more bits set: pulse `o_err_multi`, clear the settle counter, and sample nothing.
- **Settle counter.**
  - Resets to 0 whenever `sel_q` differs from its value on the previous cycle.
  - Otherwise increments while the select is valid and saturates at `SETTLE_CYCLES`.
  - The sample happens on the edge where the counter goes from `SETTLE_CYCLES-1` to `SETTLE_CYCLES`, so each dwell is sampled exactly once.
- **Glyph decode.** Works on normalised gfedcba values.

  | Pattern | Code |
  |---|---|
  | 0x3F | 0 |
  | 0x06 | 1 |
  | 0x5B | 2 |
  | 0x4F | 3 |
  | 0x66 | 4 |
  | 0x6D | 5 |
  | 0x7D or 0x7C | 6 |
  | 0x07 | 7 |
  | 0x7F | 8 |
  | 0x6F or 0x67 | 9 |
  | 0x40 (dash) | 0xA |
  | 0x00 (blank) | 0xF |
  | anything else | 0xE, and pulse `o_glyph_err` |

- **Sampling.** The decoded code is written into the working slot for that digit. The digit's bit in the 4-bit seen mask is set, and the digit's decimal point is captured.
- **Frame completion.** When a write makes the seen mask 4'b1111:
  - `o_data_bcd` and `o_dp` load from the working slots on the next edge.
  - `o_frame_valid` is high for that one cycle.
  - The seen mask is cleared.
- **Partial and repeated scans.** Scan order is irrelevant. A repeated digit before the frame completes overwrites its slot and does not complete the frame.
- **Stall counter.**
  - Counts cycles since the last change to a valid select, and saturates.
  - `o_stalled` goes high when the count reaches `STALL_CYCLES`.
  - `o_stalled` clears on the edge that registers a new valid select.
  - A stall leaves the seen mask unchanged.

## Timing
- **Reset values** (`rst`=0 at any edge, including mid-frame):
  - `o_data_bcd` = 16'hFFFF and `o_dp` = 0.
  - All pulse outputs are 0 and `o_stalled` is 0.
  - Seen mask, working slots, and counters are cleared; working slots clear to 0xF.
- **Sample latency.** Let the select pins become stable before edge E0 (`sel_q` loads at E0). The digit's slot is written at edge E0+`SETTLE_CYCLES`.
- **Frame latency.** If that write is the fourth digit, `o_frame_valid` and the new `o_data_bcd` appear after edge E0+`SETTLE_CYCLES`+1.
- **Segment timing.** Segments are sampled from `seg_q` of the same cycle as the sample edge. Segments that change during the dwell but are stable at the sample point are accepted.
- **Simultaneous events:**
  - A sample that decodes as an invalid glyph still counts toward the frame: slot = 0xE, mask bit set.
  - Frame completion and a new select on the same edge are both processed; the new dwell starts at count 0.
- **Dwell too short.** A dwell shorter than `SETTLE_CYCLES` cycles produces no sample and no error.

## Configuration
- **`SEGRX_DP_CAPTURE_EN` defined:** bit 7 of `sm_duan` is captured per digit and presented on `o_dp` with each frame.
- **Not defined:**
  - Bit 7 is ignored and `o_dp` is tied to 0.
  - Glyph decode uses bits [6:0] only, in both builds.

## Test plan
All scenarios use `SETTLE_CYCLES`=4, active-low defaults, and `STALL_CYCLES`=64.
- **Normal frame.** Drive the display value 0342 with 8 cycles per digit. Expect `o_data_bcd`=16'h0342 and exactly one `o_frame_valid` pulse, 5 cycles after the 4th digit's select settles.
- **Short dwell.** Drive a digit-2 dwell of 3 cycles, then a full scan of 1234. Expect `o_data_bcd`=16'h1234, no error pulses, and no extra frame.
- **Invalid select and glyph.**
  - Drive `sm_wei`=4'b1100: expect `o_err_multi` pulses and no slot writes.
  - Drive segment pattern 0x77 on digit 1: expect `o_glyph_err` and frame 16'hFFEF-style output with digit 1 = 0xE.
- **Stall and recovery.** Hold `sm_wei`=4'b1110 for 100 cycles: expect `o_stalled` high after 64 cycles. Resume the scan: expect `o_stalled` to drop when the new select registers, and the next frame to be valid.
- **Reset mid-frame.** Scan 3 digits, assert `rst` for 1 cycle, then complete a scan of 9876. Expect outputs at reset values during reset, then a single frame 16'h9876.
- **Decimal-point macro.** Set the DP on digit 3 of the value 5.000.
  - With `SEGRX_DP_CAPTURE_EN`: `o_dp`=4'b1000 and `o_data_bcd`=16'h5000.
  - Without it: `o_dp`=0 and `o_data_bcd`=16'h5000.
